// File: rtl/bin_to_bcd42.sv
// rtl/bin_to_bcd42.sv - 4-bit binary to 2-digit BCD converter, double-dabble, registered input
// Optional macro BIN_TO_BCD42_PIPE_EN adds an output register stage (latency 2 instead of 1).
module bin_to_bcd42 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] B,
  output logic       out_valid,
  output logic [3:0] BCD_0,
  output logic [3:0] BCD_1
);

  logic [3:0] b_q;
  logic       v_q;
  logic [7:0] conv;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // b_q only loads on accepted samples, so the converted value holds while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q <= 4'd0;
      v_q <= 1'b0;
    end else begin
      v_q <= in_valid;
      if (in_valid) b_q <= B;
    end
  end

  always_comb begin
    conv = 8'd0;
    conv = {add3(conv[7:4]), add3(conv[3:0])};
    conv = {conv[6:0], b_q[3]};
    conv = {add3(conv[7:4]), add3(conv[3:0])};
    conv = {conv[6:0], b_q[2]};
    conv = {add3(conv[7:4]), add3(conv[3:0])};
    conv = {conv[6:0], b_q[1]};
    conv = {add3(conv[7:4]), add3(conv[3:0])};
    conv = {conv[6:0], b_q[0]};
  end

`ifdef BIN_TO_BCD42_PIPE_EN
  logic [7:0] bcd_q;
  logic       ov_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q <= 8'd0;
      ov_q  <= 1'b0;
    end else begin
      ov_q <= v_q;
      if (v_q) bcd_q <= conv;
    end
  end

  assign out_valid = ov_q;
  assign BCD_1     = bcd_q[7:4];
  assign BCD_0     = bcd_q[3:0];
`else
  assign out_valid = v_q;
  assign BCD_1     = conv[7:4];
  assign BCD_0     = conv[3:0];
`endif

endmodule

// File: tb/tb_bin_to_bcd42.sv
// tb/tb_bin_to_bcd42.sv - scoreboard bench for bin_to_bcd42 (honours BIN_TO_BCD42_PIPE_EN)
module tb_bin_to_bcd42;

`ifdef BIN_TO_BCD42_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] B = 4'd0;
  logic       out_valid;
  logic [3:0] BCD_0;
  logic [3:0] BCD_1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] tens;
    logic [3:0] units;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  bin_to_bcd42 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .B(B),
    .out_valid(out_valid), .BCD_0(BCD_0), .BCD_1(BCD_1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] b);
    exp_t e;
    @(posedge clk);
    #2;
    in_valid = v;
    B = b;
    if (v) begin
      e.tens  = b / 4'd10;
      e.units = b % 4'd10;
      e.cyc   = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
    check("drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("tens", BCD_1, e.tens);
        check("units", BCD_0, e.units);
        check("latency", cyc - e.cyc, LAT);
        check("bcd1_hi_zero", BCD_1[3:1], 0);
        check("units_legal", BCD_0 <= 4'd9, 1);
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_bcd0", BCD_0, 0);
    check("rst_bcd1", BCD_1, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    drive(1, 4'd11);
    drive(0, 4'd0);
    drain();

    drive(1, 4'd3);
    drive(1, 4'd14);
    drive(0, 4'd0);
    drain();

    for (int i = 0; i < 16; i++) drive(1, 4'(i));
    drive(0, 4'd0);
    drain();

    drive(1, 4'd15);
    drive(0, 4'd7);
    repeat (LAT + 2) @(negedge clk);
    check("hold_bcd1", BCD_1, 1);
    check("hold_bcd0", BCD_0, 5);
    check("hold_out_valid", out_valid, 0);
    drain();

    drive(1, 4'd12);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst = 1'b1;
    sb.delete();
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_bcd0", BCD_0, 0);
    check("async_rst_bcd1", BCD_1, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (5) @(posedge clk);

    drive(1, 4'd9);
    drive(1, 4'd10);
    drive(1, 4'd0);
    drive(0, 4'd0);
    drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd42.md
BIN_TO_BCD42 -- requirements
Module: bin_to_bcd42

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed below.
REQ-003 clk  input  1  single clock; all registers update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  qualifies B; when low, the input sample is ignored.
REQ-006 B  input  4  unsigned binary value, 0..15.
REQ-007 out_valid  output  1  high for exactly one cycle per accepted sample, aligned with BCD_1/BCD_0.
REQ-008 BCD_0  output  4  units digit (B mod 10), range 0..9.
REQ-009 BCD_1  output  4  tens digit (B div 10), range 0..1; bits [3:1] SHALL always be 0.

Function
REQ-010 The conversion SHALL use the shift-add-3 (double-dabble) algorithm, unrolled combinationally.
  - Four shift stages.
  - Before each shift, add 3 to any BCD nibble that is >= 5.
REQ-011 For every B in 0..15, BCD_1*10 + BCD_0 SHALL equal B.
  - B <= 9: BCD_1=0, BCD_0=B.
  - B >= 10: BCD_1=1, BCD_0=B-10.
REQ-012 The input stage SHALL register B and in_valid on a clk edge; latency from sample to outputs SHALL be 1 cycle (base build).
REQ-013 out_valid SHALL assert in the cycle after a clk edge where in_valid=1, and deassert in the cycle after a clk edge where in_valid=0.
REQ-014 BCD_1/BCD_0 SHALL hold their last converted value while in_valid=0; no output change without an accepted sample.
REQ-015 Back-to-back samples (in_valid high every cycle) SHALL each be converted; throughput is 1 sample per cycle with no stall.
REQ-016 Boundary values SHALL convert as follows:
  - 0 -> 0/0
  - 9 -> 0/9
  - 10 -> 1/0
  - 15 -> 1/5
REQ-017 No output SHALL ever present an illegal BCD nibble (10..15).

Reset
REQ-018 While rst=1, the following SHALL be 0 immediately (asynchronously), independent of clk: BCD_0, BCD_1, out_valid, and all internal pipeline registers.
REQ-019 After rst deasserts, the first accepted sample SHALL appear with normal latency.
REQ-020 A sample in flight when rst asserts SHALL be discarded; out_valid SHALL NOT assert for it.

Configuration
REQ-021 Macro BIN_TO_BCD42_PIPE_EN SHALL select the output pipelining:
  - Defined: an extra register stage is added after the conversion logic; latency becomes 2 cycles, with in_valid/out_valid delayed identically and throughput still 1 per cycle.
  - Undefined: latency is 1 cycle (REQ-012).
REQ-022 Output values, hold behaviour and reset values SHALL be identical in both builds; only latency differs.

Verification
REQ-023 Apply rst, then release; set B=4'b1011 with in_valid=1 for one cycle -> after latency, BCD_1=0001, BCD_0=0001, out_valid high for 1 cycle.
REQ-024 B=4'b0011 then B=4'b1110 on consecutive cycles with in_valid=1:
  - Consecutive outputs 0/3, then 1/4.
  - out_valid high for 2 cycles.
REQ-025 Sweep B=0..15 back-to-back -> each output pair matches B div 10 / B mod 10, and BCD_1[3:1] is always 0.
REQ-026 Drive B=15 with in_valid=1, then change B to 7 with in_valid=0 -> outputs hold 1/5, out_valid=0.
REQ-027 Assert rst asynchronously mid-stream (between clk edges) with B=12 in flight -> outputs and out_valid go to 0 at once, and no out_valid for 12 after release.
REQ-028 Repeat REQ-023 to REQ-027 with BIN_TO_BCD42_PIPE_EN defined -> identical values, latency 2 cycles.
